// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned PH_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle between a pulse train controller and the generator.
interface pulse_train_gen_if #(
    parameter int unsigned CNT_W = pulse_train_pkg::CNT_W_DEF,
    parameter int unsigned PH_W  = pulse_train_pkg::PH_W_DEF
) ();

    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_count;
    logic [PH_W-1:0]  i_high;
    logic [PH_W-1:0]  i_low;
    logic             o_signal;
    logic             o_gate;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_emitted;

    modport master (
        output i_start, i_abort, i_count, i_high, i_low,
        input  o_signal, o_gate, o_busy, o_done, o_emitted
    );

    modport slave (
        input  i_start, i_abort, i_count, i_high, i_low,
        output o_signal, o_gate, o_busy, o_done, o_emitted
    );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; a zero length loads as 1.
module phase_timer #(
    parameter int unsigned PH_W = pulse_train_pkg::PH_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PH_W-1:0] len,
    output logic            expired_c
);

    logic [PH_W-1:0] count_q;
    logic [PH_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (len == '0) ? PH_W'(1) : len;
        end else if (count_q != '0) begin
            count_d = count_q - PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Counter holds the cycles left in the phase, including the current one.
    assign expired_c = (count_q == PH_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a counted train of pulses with programmable high/low phases inside a gate window.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PH_W  = PH_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    pulse_train_gen_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  high_q, high_d;
    logic [PH_W-1:0]  low_q, low_d;
    logic [CNT_W-1:0] emitted_q, emitted_d;
    logic             signal_q, signal_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load_c;
    logic [PH_W-1:0]  load_len_c;
    logic             expired_c;

    phase_timer #(.PH_W(PH_W)) u_phase_timer (
        .clk       (i_clk),
        .rst       (i_reset),
        .load      (load_c),
        .len       (load_len_c),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_d     = high_q;
        low_d      = low_q;
        emitted_d  = emitted_q;
        load_c     = 1'b0;
        load_len_c = high_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    cnt_d     = bus.i_count;
                    high_d    = bus.i_high;
                    low_d     = bus.i_low;
                    emitted_d = '0;
                    state_d   = (bus.i_count == '0) ? ST_DONE : ST_LEAD;
                end
            end
            ST_LEAD: begin
                state_d   = ST_HIGH;
                load_c    = 1'b1;
                emitted_d = emitted_q + CNT_W'(1);
            end
            ST_HIGH: begin
                if (expired_c) begin
                    state_d    = ST_LOW;
                    load_c     = 1'b1;
                    load_len_c = low_q;
                end
            end
            ST_LOW: begin
                if (expired_c) begin
                    // emitted never exceeds the latched count, so it cannot wrap
                    if (emitted_q < cnt_q) begin
                        state_d   = ST_HIGH;
                        load_c    = 1'b1;
                        emitted_d = emitted_q + CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.i_abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            load_c    = 1'b0;
            emitted_d = emitted_q;
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        signal_d = (state_d == ST_HIGH);
        gate_d   = (state_d == ST_LEAD) || (state_d == ST_HIGH) || (state_d == ST_LOW);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            high_q    <= '0;
            low_q     <= '0;
            emitted_q <= '0;
            signal_q  <= 1'b0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            low_q     <= low_d;
            emitted_q <= emitted_d;
            signal_q  <= signal_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_signal  = signal_q;
    assign bus.o_gate    = gate_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_emitted = emitted_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen; k counts cycles after the edge that sampled i_start.
module tb_pulse_train_gen;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    logic [31:0] ec;
    logic        sp;

    pulse_train_gen_if #(.CNT_W(32), .PH_W(16)) bus ();

    pulse_train_gen #(.CNT_W(32), .PH_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Gated rising-edge counter looped back on the generator outputs.
    always @(posedge clk) begin
        if (clr) begin
            ec <= '0;
            sp <= 1'b0;
        end else begin
            sp <= bus.o_signal;
            if (bus.o_gate && bus.o_signal && !sp) ec <= ec + 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] st();
        return {bus.o_signal, bus.o_gate, bus.o_busy, bus.o_done};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e;
        int edges;
        int done_k;
        logic prev;
        int k;

        rst = 1'b1;
        clr = 1'b1;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_count = '0;
        bus.i_high  = '0;
        bus.i_low   = '0;
        tick();
        tick();
        check("reset_outputs", 64'(st()), 64'h0);
        check("reset_emitted", 64'(bus.o_emitted), 64'd0);
        rst = 1'b0;
        clr = 1'b0;

        // count=3 high=2 low=3, with a start and new inputs injected mid-train
        bus.i_count = 32'd3;
        bus.i_high  = 16'd2;
        bus.i_low   = 16'd3;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int kk = 1; kk <= 18; kk++) begin
            e[3] = (kk == 2) || (kk == 3) || (kk == 7) || (kk == 8) || (kk == 12) || (kk == 13);
            e[2] = (kk <= 16);
            e[1] = (kk <= 17);
            e[0] = (kk == 17);
            check($sformatf("t3x2x3_k%0d", kk), 64'(st()), 64'(e));
            if (kk == 17) check("t3x2x3_emitted", 64'(bus.o_emitted), 64'd3);
            bus.i_start = (kk == 5);
            if (kk == 5) begin
                bus.i_count = 32'd7;
                bus.i_high  = 16'd9;
                bus.i_low   = 16'd0;
            end
            if (kk < 18) tick();
        end

        // count=0 goes straight to DONE
        bus.i_count = 32'd0;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("zero_k1", 64'(st()), 64'(4'b0011));
        check("zero_emitted", 64'(bus.o_emitted), 64'd0);
        tick();
        check("zero_k2", 64'(st()), 64'h0);

        // high=0 low=0 clamp to 1-cycle phases
        bus.i_count = 32'd4;
        bus.i_high  = 16'd0;
        bus.i_low   = 16'd0;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int kk = 1; kk <= 11; kk++) begin
            e[3] = (kk >= 2) && (kk <= 8) && ((kk % 2) == 0);
            e[2] = (kk <= 9);
            e[1] = (kk <= 10);
            e[0] = (kk == 10);
            check($sformatf("clamp_k%0d", kk), 64'(st()), 64'(e));
            if (kk == 2)  check("clamp_emit_first", 64'(bus.o_emitted), 64'd1);
            if (kk == 10) check("clamp_emitted", 64'(bus.o_emitted), 64'd4);
            if (kk < 11) tick();
        end

        // abort during the 3rd HIGH of a 10x5x5 train
        bus.i_count = 32'd10;
        bus.i_high  = 16'd5;
        bus.i_low   = 16'd5;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (21) tick();
        check("abort_pre_state", 64'(st()), 64'(4'b1110));
        check("abort_pre_emitted", 64'(bus.o_emitted), 64'd3);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_state", 64'(st()), 64'h0);
        check("abort_emitted", 64'(bus.o_emitted), 64'd3);
        tick();
        check("abort_no_done", 64'(st()), 64'h0);

        // abort beats start in IDLE
        bus.i_count = 32'd2;
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        check("abort_start_state", 64'(st()), 64'h0);
        check("abort_start_emitted", 64'(bus.o_emitted), 64'd3);

        // reset mid-HIGH, with start and abort also high
        bus.i_count = 32'd5;
        bus.i_high  = 16'd3;
        bus.i_low   = 16'd2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        check("rst_mid_pre", 64'(st()), 64'(4'b1110));
        rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        check("rst_mid_state", 64'(st()), 64'h0);
        check("rst_mid_emitted", 64'(bus.o_emitted), 64'd0);
        tick();
        check("rst_prio_state", 64'(st()), 64'h0);
        rst = 1'b0;
        bus.i_abort = 1'b0;
        tick();
        bus.i_start = 1'b0;
        edges  = 0;
        done_k = 0;
        prev   = 1'b0;
        for (int kk = 1; kk <= 40; kk++) begin
            if (bus.o_signal && !prev) edges++;
            prev = bus.o_signal;
            if (bus.o_done && (done_k == 0)) done_k = kk;
            if (kk == 27) check("post_rst_emitted", 64'(bus.o_emitted), 64'd5);
            tick();
        end
        check("post_rst_done_cycle", 64'(done_k), 64'd27);
        check("post_rst_edges", 64'(edges), 64'd5);

        // 1000-pulse loopback into the gated edge counter
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.i_count = 32'd1000;
        bus.i_high  = 16'd1;
        bus.i_low   = 16'd1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        k = 1;
        while (!bus.o_done && (k < 2100)) begin
            tick();
            k++;
        end
        check("loop_done_cycle", 64'(k), 64'd2002);
        check("loop_counter", 64'(ec), 64'd1000);
        check("loop_emitted", 64'(bus.o_emitted), 64'd1000);
        tick();
        check("loop_idle", 64'(st()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
